mouse_source_arbiter: RTL

- Merges two relative-mouse event sources, A (USB HID host) and B (PS/2 host), into the single toggle-based stream consumed by the serial-mouse emulator: ms_x, ms_y, ms_b, ms_upd.
- Accumulates each source's motion with saturation and round-robins between sources with pending data.
- Paces output updates to at most one per serial packet time, so the 1200-baud emitter is never flooded and no motion is lost.

---
 rtl/mouse_source_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mouse_source_arbiter.sv
// Merges USB (A) and PS/2 (B) relative mouse sources into one paced
// toggle stream for the serial mouse emitter.
module mouse_source_arbiter #(
  parameter int CLKFREQ    = 50_000_000,
  parameter int GAP_CYCLES = CLKFREQ / 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a_x,
  input  logic [7:0] a_y,
  input  logic [2:0] a_b,
  input  logic       a_upd,
  input  logic [7:0] b_x,
  input  logic [7:0] b_y,
  input  logic [2:0] b_b,
  input  logic       b_upd,
  input  logic       en_a,
  input  logic       en_b,
  output logic [7:0] ms_x,
  output logic [7:0] ms_y,
  output logic [2:0] ms_b,
  output logic       ms_upd,
  output logic       ms_src
);

  localparam int TW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic {IDLE, GAP} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          last_grant;
  logic          prev_a_upd;
  logic          prev_b_upd;

  logic [7:0] acc_x [2];
  logic [7:0] acc_y [2];
  logic [2:0] btn   [2];
  logic [1:0] pending;

  logic [7:0] dx [2];
  logic [7:0] dy [2];
  logic [2:0] db [2];
  logic [1:0] en;
  logic [1:0] ev;
  logic [1:0] pend_eff;
  logic [1:0] take;
  logic       grant_v;
  logic       g;

  logic [7:0] nxt_x [2];
  logic [7:0] nxt_y [2];
  logic [2:0] nxt_b [2];
  logic [1:0] nxt_p;

  // Add two signed bytes in 9 bits and clamp instead of wrapping.
  function automatic logic [7:0] sat8(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [8:0] sum;
    sum = {a[7], a} + {b[7], b};
    if (sum[8] != sum[7])
      return sum[8] ? 8'h80 : 8'h7F;
    return sum[7:0];
  endfunction

  assign dx[0] = a_x;
  assign dx[1] = b_x;
  assign dy[0] = a_y;
  assign dy[1] = b_y;
  assign db[0] = a_b;
  assign db[1] = b_b;
  assign en    = {en_b, en_a};
  assign ev[0] = en_a & (a_upd != prev_a_upd);
  assign ev[1] = en_b & (b_upd != prev_b_upd);

  // Grant selection and next accumulator state for both sources.
  always_comb begin
    pend_eff = pending & en;
    grant_v  = (state == IDLE) && (pend_eff != 2'b00);
    g        = (pend_eff == 2'b11) ? ~last_grant : pend_eff[1];
    take     = 2'b00;
    take[g]  = grant_v;
    nxt_p    = 2'b00;
    for (int s = 0; s < 2; s++) begin
      nxt_x[s] = take[s] ? 8'h00 : acc_x[s];
      nxt_y[s] = take[s] ? 8'h00 : acc_y[s];
      nxt_b[s] = btn[s];
      nxt_p[s] = pending[s] & ~take[s];
      if (!en[s]) begin
        nxt_x[s] = 8'h00;
        nxt_y[s] = 8'h00;
        nxt_b[s] = 3'b000;
        nxt_p[s] = 1'b0;
      end else if (ev[s]) begin
        nxt_x[s] = sat8(nxt_x[s], dx[s]);
        nxt_y[s] = sat8(nxt_y[s], dy[s]);
        nxt_b[s] = db[s];
        nxt_p[s] = 1'b1;
      end
    end
  end

  // Accumulators, pacing FSM and registered outputs.
  always_ff @(posedge clk) begin
    prev_a_upd <= a_upd;
    prev_b_upd <= b_upd;
    if (reset) begin
      ms_x       <= 8'h00;
      ms_y       <= 8'h00;
      ms_b       <= 3'b000;
      ms_upd     <= 1'b0;
      ms_src     <= 1'b0;
      last_grant <= 1'b1;
      timer      <= '0;
      state      <= IDLE;
      pending    <= 2'b00;
      for (int s = 0; s < 2; s++) begin
        acc_x[s] <= 8'h00;
        acc_y[s] <= 8'h00;
        btn[s]   <= 3'b000;
      end
    end else begin
      pending <= nxt_p;
      for (int s = 0; s < 2; s++) begin
        acc_x[s] <= nxt_x[s];
        acc_y[s] <= nxt_y[s];
        btn[s]   <= nxt_b[s];
      end
      unique case (state)
        IDLE: begin
          if (grant_v) begin
            ms_x       <= acc_x[g];
            ms_y       <= acc_y[g];
            ms_b       <= (btn[0] & {3{en_a}})
                        | (btn[1] & {3{en_b}});
            ms_src     <= g;
            ms_upd     <= ~ms_upd;
            last_grant <= g;
            timer      <= TW'(GAP_CYCLES - 2);
            state      <= GAP;
          end
        end
        GAP: begin
          if (timer == '0) state <= IDLE;
          else             timer <= timer - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
